// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter owning the register file write port (WE3/A3/WD3), shared by ALU and LSU.
// Build option REGFILE_WB_CLEAR_EN adds a post-reset clear of x1..x(NUM_REGS-1).
module regfile_wb_arbiter #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_wd,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_wd,
  output logic              lsu_ready,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              init_done,
  output logic              err_addr
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_LSU = 1'b1} grant_e;

  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              err_addr_q, err_addr_d;
  logic              init_done_q, init_done_d;
  grant_e            last_grant_q, last_grant_d;

  logic              run;
  logic              alu_xfer, lsu_xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_wd;

`ifdef REGFILE_WB_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  assign run = (state_q == S_RUN);
`else
  assign run = 1'b1;
`endif

  // Tie goes to whichever port was not granted last; an idle cycle reports both ready.
  assign alu_ready = run && (!lsu_valid || (alu_valid && last_grant_q == GRANT_LSU));
  assign lsu_ready = run && (!alu_valid || (lsu_valid && last_grant_q == GRANT_ALU));

  always_comb begin
    alu_xfer = alu_valid && alu_ready;
    lsu_xfer = lsu_valid && lsu_ready;
    sel_rd   = lsu_xfer ? lsu_rd : alu_rd;
    sel_wd   = lsu_xfer ? lsu_wd : alu_wd;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    we3_d        = 1'b0;
    a3_d         = a3_q;
    wd3_d        = wd3_q;
    err_addr_d   = 1'b0;
    last_grant_d = last_grant_q;
`ifdef REGFILE_WB_CLEAR_EN
    init_done_d  = init_done_q;
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;

    if (state_q == S_CLEAR) begin
      we3_d     = 1'b1;
      a3_d      = clr_ptr_q;
      wd3_d     = '0;
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST_REG) begin
        state_d     = S_RUN;
        init_done_d = 1'b1;
      end
    end else
`else
    init_done_d  = 1'b1;
`endif
    if (alu_xfer || lsu_xfer) begin
      a3_d         = sel_rd;
      wd3_d        = sel_wd;
      // x0 and out-of-range targets are consumed as grants but never written.
      we3_d        = (sel_rd != '0) && (sel_rd <= LAST_REG);
      err_addr_d   = (sel_rd > LAST_REG);
      last_grant_d = lsu_xfer ? GRANT_LSU : GRANT_ALU;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      we3_q        <= 1'b0;
      a3_q         <= '0;
      wd3_q        <= '0;
      err_addr_q   <= 1'b0;
      init_done_q  <= 1'b0;
      last_grant_q <= GRANT_LSU;
`ifdef REGFILE_WB_CLEAR_EN
      state_q      <= S_CLEAR;
      clr_ptr_q    <= ADDR_W'(1);
`endif
    end else begin
      we3_q        <= we3_d;
      a3_q         <= a3_d;
      wd3_q        <= wd3_d;
      err_addr_q   <= err_addr_d;
      init_done_q  <= init_done_d;
      last_grant_q <= last_grant_d;
`ifdef REGFILE_WB_CLEAR_EN
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
`endif
    end
  end

  assign WE3       = we3_q;
  assign A3        = a3_q;
  assign WD3       = wd3_q;
  assign err_addr  = err_addr_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; models the register file as a negedge-write array.
// Expectations follow the REGFILE_WB_CLEAR_EN build option.
module tb_regfile_wb_arbiter;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic              CLK = 1'b0;
  logic              reset_n;
  logic              alu_valid, lsu_valid;
  logic [ADDR_W-1:0] alu_rd, lsu_rd;
  logic [DATA_W-1:0] alu_wd, lsu_wd;
  logic              alu_ready, lsu_ready;
  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic              init_done, err_addr;

  logic [DATA_W-1:0] rf [NUM_REGS];

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
    .WE3(WE3), .A3(A3), .WD3(WD3), .init_done(init_done), .err_addr(err_addr)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (WE3 === 1'b1 && A3 < ADDR_W'(NUM_REGS)) rf[A3[3:0]] <= WD3;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_init_seq(input string tag);
`ifdef REGFILE_WB_CLEAR_EN
    int nonzero = 0;
    for (int i = 1; i < NUM_REGS; i++) begin
      total++;
      if (alu_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s clear_ready[%0d]: got alu_ready=%b, want 0", tag, i, alu_ready);
      end
      tick();
      total++;
      if (WE3 !== 1'b1 || A3 !== ADDR_W'(i) || WD3 !== '0) begin
        bad++;
        $display("FAIL %s clear_write[%0d]: got we=%b a3=%0d wd3=%h, want we=1 a3=%0d wd3=0",
                 tag, i, WE3, A3, WD3, i);
      end
      if (i < NUM_REGS - 1) begin
        total++;
        if (init_done !== 1'b0) begin
          bad++;
          $display("FAIL %s init_early[%0d]: got init_done=%b, want 0", tag, i, init_done);
        end
      end
    end
    tick();
    total++;
    if (WE3 !== 1'b0 || init_done !== 1'b1) begin
      bad++;
      $display("FAIL %s clear_end: got we=%b init_done=%b, want we=0 init_done=1", tag, WE3, init_done);
    end
    for (int i = 1; i < NUM_REGS; i++) if (rf[i] !== '0) nonzero++;
    total++;
    if (nonzero != 0) begin
      bad++;
      $display("FAIL %s rf_cleared: got %0d nonzero regs, want 0", tag, nonzero);
    end
`else
    int we_seen = 0;
    tick();
    total++;
    if (init_done !== 1'b1 || WE3 !== 1'b0) begin
      bad++;
      $display("FAIL %s init_direct: got init_done=%b we=%b, want init_done=1 we=0", tag, init_done, WE3);
    end
    repeat (NUM_REGS - 1) begin
      tick();
      if (WE3 !== 1'b0) we_seen++;
    end
    total++;
    if (we_seen != 0) begin
      bad++;
      $display("FAIL %s no_clear_writes: got %0d write cycles, want 0", tag, we_seen);
    end
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_rd = '0; lsu_rd = '0; alu_wd = '0; lsu_wd = '0;
    repeat (3) tick();
    total++;
    if (WE3 !== 1'b0 || A3 !== '0 || WD3 !== '0) begin
      bad++;
      $display("FAIL reset_port: got we=%b a3=%0d wd3=%h, want 0/0/0", WE3, A3, WD3);
    end
    total++;
    if (init_done !== 1'b0 || err_addr !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got init_done=%b err=%b, want 0/0", init_done, err_addr);
    end
    reset_n = 1'b1;
    run_init_seq("reset");
  endtask

  task automatic test_single();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    #1;
    total++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_ready: got alu=%b lsu=%b, want 1/0", alu_ready, lsu_ready);
    end
    tick();
    alu_valid = 1'b0;
    total++;
    if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_write: got we=%b a3=%0d wd3=%h, want 1/5/deadbeef", WE3, A3, WD3);
    end
    @(negedge CLK); #1;
    total++;
    if (rf[5] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_rf: got x5=%h, want deadbeef", rf[5]);
    end
    tick();
    total++;
    if (WE3 !== 1'b0 || A3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL idle_hold: got we=%b a3=%0d wd3=%h, want 0/5/deadbeef", WE3, A3, WD3);
    end
  endtask

  task automatic test_rd_special();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'h55;
    #1;
    total++;
    if (lsu_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd0_ready: got lsu_ready=%b, want 1", lsu_ready);
    end
    tick();
    lsu_rd = 5'd20; lsu_wd = 32'h66;
    total++;
    if (WE3 !== 1'b0 || err_addr !== 1'b0) begin
      bad++;
      $display("FAIL rd0_write: got we=%b err=%b, want 0/0", WE3, err_addr);
    end
    #1;
    total++;
    if (lsu_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd20_ready: got lsu_ready=%b, want 1", lsu_ready);
    end
    tick();
    lsu_valid = 1'b0;
    total++;
    if (WE3 !== 1'b0 || err_addr !== 1'b1) begin
      bad++;
      $display("FAIL rd20_write: got we=%b err=%b, want 0/1", WE3, err_addr);
    end
    tick();
    total++;
    if (err_addr !== 1'b0 || WE3 !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse: got err=%b we=%b, want 0/0", err_addr, WE3);
    end
    total++;
    if (rf[5] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rd_special_rf: got x5=%h, want deadbeef", rf[5]);
    end
  endtask

  task automatic test_both();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_wd = 32'h22;
    #1;
    total++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      bad++;
      $display("FAIL both_first: got alu=%b lsu=%b, want 1/0", alu_ready, lsu_ready);
    end
    tick();
    alu_valid = 1'b0;
    total++;
    if (WE3 !== 1'b1 || A3 !== 5'd3 || WD3 !== 32'h11) begin
      bad++;
      $display("FAIL both_w1: got we=%b a3=%0d wd3=%h, want 1/3/11", WE3, A3, WD3);
    end
    #1;
    total++;
    if (lsu_ready !== 1'b1) begin
      bad++;
      $display("FAIL both_second: got lsu_ready=%b, want 1", lsu_ready);
    end
    tick();
    lsu_valid = 1'b0;
    total++;
    if (WE3 !== 1'b1 || A3 !== 5'd4 || WD3 !== 32'h22) begin
      bad++;
      $display("FAIL both_w2: got we=%b a3=%0d wd3=%h, want 1/4/22", WE3, A3, WD3);
    end
    tick();
    total++;
    if (rf[3] !== 32'h11 || rf[4] !== 32'h22) begin
      bad++;
      $display("FAIL both_rf: got x3=%h x4=%h, want 11/22", rf[3], rf[4]);
    end
  endtask

  task automatic test_alternate();
    int  ac = 0;
    int  lc = 0;
    logic exp_alu;
    alu_valid = 1'b1; alu_rd = 5'd8;
    lsu_valid = 1'b1; lsu_rd = 5'd9;
    for (int k = 0; k < 6; k++) begin
      alu_wd = 32'hA000 + ac;
      lsu_wd = 32'hB000 + lc;
      exp_alu = (k % 2 == 0);
      #1;
      total++;
      if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin
        bad++;
        $display("FAIL alt_grant[%0d]: got alu=%b lsu=%b, want %b/%b", k, alu_ready, lsu_ready, exp_alu, !exp_alu);
      end
      tick();
      total++;
      if (WE3 !== 1'b1 || A3 !== (exp_alu ? 5'd8 : 5'd9) ||
          WD3 !== (exp_alu ? 32'hA000 + ac : 32'hB000 + lc)) begin
        bad++;
        $display("FAIL alt_write[%0d]: got we=%b a3=%0d wd3=%h", k, WE3, A3, WD3);
      end
      if (exp_alu) ac++; else lc++;
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    total++;
    if (WE3 !== 1'b0) begin
      bad++;
      $display("FAIL alt_idle: got we=%b, want 0", WE3);
    end
  endtask

  task automatic test_same_rd();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_wd = 32'hC1;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wd = 32'hC2;
    tick();
    alu_valid = 1'b0;
    total++;
    if (WE3 !== 1'b1 || A3 !== 5'd10 || WD3 !== 32'hC1) begin
      bad++;
      $display("FAIL same_w1: got we=%b a3=%0d wd3=%h, want 1/10/c1", WE3, A3, WD3);
    end
    tick();
    lsu_valid = 1'b0;
    total++;
    if (WE3 !== 1'b1 || A3 !== 5'd10 || WD3 !== 32'hC2) begin
      bad++;
      $display("FAIL same_w2: got we=%b a3=%0d wd3=%h, want 1/10/c2", WE3, A3, WD3);
    end
    tick();
    total++;
    if (rf[10] !== 32'hC2) begin
      bad++;
      $display("FAIL same_rf: got x10=%h, want c2", rf[10]);
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] exp_x7;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h70;
    tick();
    total++;
    if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'h70) begin
      bad++;
      $display("FAIL mid_pre: got we=%b a3=%0d wd3=%h, want 1/7/70", WE3, A3, WD3);
    end
    alu_wd = 32'h77;
    reset_n = 1'b0;
    tick();
    total++;
    if (WE3 !== 1'b0 || A3 !== '0 || init_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got we=%b a3=%0d init_done=%b, want 0/0/0", WE3, A3, init_done);
    end
    reset_n = 1'b1;
    alu_valid = 1'b0;
    run_init_seq("mid");
`ifdef REGFILE_WB_CLEAR_EN
    exp_x7 = '0;
`else
    exp_x7 = 32'h70;
`endif
    total++;
    if (rf[7] !== exp_x7) begin
      bad++;
      $display("FAIL mid_rf: got x7=%h, want %h", rf[7], exp_x7);
    end
  endtask

  task automatic test_first_tie();
    alu_valid = 1'b1; alu_rd = 5'd11; alu_wd = 32'hE1;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_wd = 32'hE2;
    #1;
    total++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      bad++;
      $display("FAIL tie_after_reset: got alu=%b lsu=%b, want 1/0", alu_ready, lsu_ready);
    end
    tick();
    alu_valid = 1'b0;
    tick();
    lsu_valid = 1'b0;
    total++;
    if (WE3 !== 1'b1 || A3 !== 5'd12 || WD3 !== 32'hE2) begin
      bad++;
      $display("FAIL tie_second: got we=%b a3=%0d wd3=%h, want 1/12/e2", WE3, A3, WD3);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'h5A5A_0000 | i;
    test_reset();
    test_single();
    test_rd_special();
    test_both();
    test_alternate();
    test_same_rd();
    test_reset_mid();
    test_first_tie();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
